// File: rtl/i2c_arb_pkg.sv
// Shared types and defaults for the I2C bus arbiter: 2-bit state encoding,
// default guard/timeout lengths and the timer width helper.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT_WR = 2'd1,
    ST_GRANT_RD = 2'd2,
    ST_GUARD    = 2'd3
  } arb_state_e;

  localparam int unsigned DEF_GUARD_CYCLES   = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 100000;

  // One timer serves both guard and tenure, so it must hold the larger limit.
  function automatic int unsigned arb_cnt_width(input int unsigned timeout_c,
                                                input int unsigned guard_c);
    int unsigned m;
    m = (timeout_c > guard_c) ? timeout_c : guard_c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/i2c_arb_timer.sv
// Saturating up-counter with synchronous clear and terminal-count flag.
// Latency: tc_o is combinational on the registered count; no backpressure.
module i2c_arb_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Two-requester (write/read engine) I2C bus arbiter with guard gap and tenure timeout.
// Latency: 1 clk request-to-grant; requests are levels held until done, no backpressure.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES   = DEF_GUARD_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_wr,
  input  logic req_rd,
  input  logic done_wr,
  input  logic done_rd,
  output logic gnt_wr,
  output logic gnt_rd,
  output logic rw,
  output logic busy,
  output logic timeout_err
);

  localparam int unsigned CW = arb_cnt_width(TIMEOUT_CYCLES, GUARD_CYCLES);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GD_LIM = (GUARD_CYCLES == 0) ? '0 : CW'(GUARD_CYCLES - 1);
  localparam bit GUARD_EN = (GUARD_CYCLES != 0);

  arb_state_e    state_q;
  logic          gnt_wr_q, gnt_rd_q, rw_q, busy_q, terr_q, last_rd_q;
  logic          in_grant, own_done, own_req, own_end, pick_rd;
  logic          tmr_clr, tmr_en, tmr_tc;
  logic [CW-1:0] tmr_lim;

  assign in_grant = (state_q == ST_GRANT_WR) || (state_q == ST_GRANT_RD);
  assign own_done = (state_q == ST_GRANT_RD) ? done_rd : done_wr;
  assign own_req  = (state_q == ST_GRANT_RD) ? req_rd  : req_wr;
  assign own_end  = own_done || !own_req;
  // On a tie the requester that was not served last wins.
  assign pick_rd  = req_rd && (!req_wr || !last_rd_q);

  // Timer idles at zero in IDLE and restarts at every tenure end, so both
  // GRANT and GUARD begin with a count of zero.
  assign tmr_lim = in_grant ? TO_LIM : GD_LIM;
  assign tmr_clr = (state_q == ST_IDLE) || (in_grant && (own_end || tmr_tc));
  assign tmr_en  = !tmr_clr;

  i2c_arb_timer #(.W(CW)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i (tmr_lim),
    .tc_o    (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_wr_q  <= 1'b0;
      gnt_rd_q  <= 1'b0;
      rw_q      <= 1'b0;
      busy_q    <= 1'b0;
      terr_q    <= 1'b0;
      last_rd_q <= 1'b1;
    end else begin
      terr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_wr || req_rd) begin
            state_q   <= pick_rd ? ST_GRANT_RD : ST_GRANT_WR;
            gnt_rd_q  <= pick_rd;
            gnt_wr_q  <= !pick_rd;
            rw_q      <= pick_rd;
            last_rd_q <= pick_rd;
            busy_q    <= 1'b1;
          end
        end
        ST_GRANT_WR, ST_GRANT_RD: begin
          // A normal end (done or req drop) outranks the timeout.
          if (own_end || tmr_tc) begin
            gnt_wr_q <= 1'b0;
            gnt_rd_q <= 1'b0;
            terr_q   <= !own_end;
            if (GUARD_EN) begin
              state_q <= ST_GUARD;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              rw_q    <= 1'b0;
            end
          end
        end
        ST_GUARD: begin
          if (tmr_tc) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            rw_q    <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt_wr      = gnt_wr_q;
  assign gnt_rd      = gnt_rd_q;
  assign rw          = rw_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: directed scenarios plus randomized engine traffic
// compared against a tenure-level reference model.
module tb_i2c_bus_arbiter;

  localparam int G = 4;
  localparam int T = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_wr = 1'b0, req_rd = 1'b0, done_wr = 1'b0, done_rd = 1'b0;
  logic gnt_wr, gnt_rd, rw, busy, timeout_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  i2c_bus_arbiter #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_wr      (req_wr),
    .req_rd      (req_rd),
    .done_wr     (done_wr),
    .done_rd     (done_rd),
    .gnt_wr      (gnt_wr),
    .gnt_rd      (gnt_rd),
    .rw          (rw),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // Reference model: who owns the bus, how long they have held it,
  // how many guard cycles remain and which side the guard follows.
  int m_owner;   // 0 none, 1 write, 2 read
  int m_age;
  int m_guard;
  bit m_gw;
  bit m_last_rd;
  bit m_terr;

  function automatic void m_reset();
    m_owner = 0; m_age = 0; m_guard = 0; m_gw = 1'b0; m_last_rd = 1'b1; m_terr = 1'b0;
  endfunction

  function automatic void m_step();
    bit od, orq;
    m_terr = 1'b0;
    if (m_owner != 0) begin
      od  = (m_owner == 1) ? done_wr : done_rd;
      orq = (m_owner == 1) ? req_wr : req_rd;
      if (od || !orq || m_age == T - 1) begin
        m_terr  = !(od || !orq);
        m_gw    = (m_owner == 2);
        m_owner = 0;
        m_guard = G;
      end else begin
        m_age++;
      end
    end else if (m_guard > 0) begin
      m_guard--;
    end else if (req_wr || req_rd) begin
      m_owner   = (req_rd && (!req_wr || !m_last_rd)) ? 2 : 1;
      m_last_rd = (m_owner == 2);
      m_age     = 0;
    end
  endfunction

  function automatic logic [4:0] exp_vec();
    return {m_owner == 1, m_owner == 2, (m_owner == 2) || (m_guard > 0 && m_gw),
            (m_owner != 0) || (m_guard > 0), m_terr};
  endfunction

  function automatic logic [4:0] dut_vec();
    return {gnt_wr, gnt_rd, rw, busy, timeout_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_wr = 1'b0; req_rd = 1'b0; done_wr = 1'b0; done_rd = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (dut_vec() !== 5'b0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=%b", dut_vec(), 5'b0);
    end
    m_reset();
    apply_reset();
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_model got=%b exp=%b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_single_write();
    apply_reset();
    req_wr = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      done_wr = (c == 11);
      req_wr  = (c <= 11);
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL single_wr_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
      if (c == 1) begin
        total++;
        if ({gnt_wr, rw} !== 2'b10) begin
          bad++; $display("FAIL single_wr_grant gnt_wr,rw=%b exp=10", {gnt_wr, rw});
        end
      end
      if (c == 11) begin
        total++;
        if (gnt_wr !== 1'b0) begin
          bad++; $display("FAIL single_wr_release gnt_wr=%b exp=0", gnt_wr);
        end
      end
      if (c == 14 || c == 15) begin
        total++;
        if (busy !== (c == 14)) begin
          bad++; $display("FAIL single_wr_guard c=%0d busy=%b exp=%b", c, busy, c == 14);
        end
      end
    end
    done_wr = 1'b0;
  endtask

  task automatic test_tie();
    apply_reset();
    for (int c = 1; c <= 20; c++) begin
      req_wr  = (c <= 5);
      done_wr = (c == 5);
      req_rd  = (c <= 14);
      done_rd = (c == 14);
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL tie_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
      if (c == 1 || c == 9 || c == 10) begin
        total++;
        if ({gnt_wr, gnt_rd, rw} !== ((c == 1) ? 3'b100 : (c == 9) ? 3'b000 : 3'b011)) begin
          bad++; $display("FAIL tie_order c=%0d gnt_wr,gnt_rd,rw=%b", c, {gnt_wr, gnt_rd, rw});
        end
      end
    end
    done_rd = 1'b0;
  endtask

  task automatic test_round_robin();
    int order[$];
    int hw, hr;
    bit pw, pr;
    hw = 0; hr = 0; pw = 1'b0; pr = 1'b0;
    apply_reset();
    req_wr = 1'b1; req_rd = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      done_wr = gnt_wr && (hw == 3);
      done_rd = gnt_rd && (hr == 3);
      tick();
      total++;
      if (gnt_wr && gnt_rd) begin
        bad++; $display("FAIL rr_overlap c=%0d both grants high", c);
      end
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL rr_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
      if (gnt_wr && !pw) order.push_back(1);
      if (gnt_rd && !pr) order.push_back(2);
      hw = gnt_wr ? hw + 1 : 0;
      hr = gnt_rd ? hr + 1 : 0;
      pw = gnt_wr; pr = gnt_rd;
    end
    total++;
    if (order.size() != 4 || order[0] != 1 || order[1] != 2 || order[2] != 1 || order[3] != 2) begin
      bad++; $display("FAIL rr_sequence got %p exp '{1,2,1,2}", order);
    end
    req_wr = 1'b0; req_rd = 1'b0; done_wr = 1'b0; done_rd = 1'b0;
  endtask

  task automatic test_timeout();
    int hi, tcnt, tcyc;
    hi = 0; tcnt = 0; tcyc = -1;
    apply_reset();
    req_rd = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL timeout_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
      if (gnt_rd) hi++;
      if (timeout_err) begin
        tcnt++; tcyc = c;
        total++;
        if ({busy, rw, gnt_rd} !== 3'b110) begin
          bad++; $display("FAIL timeout_guard busy,rw,gnt_rd=%b exp=110", {busy, rw, gnt_rd});
        end
        req_rd = 1'b0;
      end
    end
    total++;
    if (hi != T || tcnt != 1 || tcyc != T + 1) begin
      bad++; $display("FAIL timeout_len gnt_cycles=%0d pulses=%0d at=%0d exp %0d/1/%0d", hi, tcnt, tcyc, T, T + 1);
    end
    req_rd = 1'b0;
  endtask

  task automatic test_collision();
    int tcnt;
    tcnt = 0;
    apply_reset();
    for (int c = 1; c <= 30; c++) begin
      req_rd  = (c <= T + 1);
      done_rd = (c == T + 1);
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL collide_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
      if (timeout_err) tcnt++;
      if (c == T + 1) begin
        total++;
        if ({gnt_rd, timeout_err, busy} !== 3'b001) begin
          bad++; $display("FAIL collide_edge gnt_rd,terr,busy=%b exp=001", {gnt_rd, timeout_err, busy});
        end
      end
    end
    total++;
    if (tcnt != 0) begin
      bad++; $display("FAIL collide_pulses got=%0d exp=0", tcnt);
    end
    done_rd = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_rd = 1'b1;
    for (int c = 1; c <= 3; c++) tick();
    total++;
    if (gnt_rd !== 1'b1) begin
      bad++; $display("FAIL rmid_pre gnt_rd=%b exp=1", gnt_rd);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (dut_vec() !== 5'b0) begin
      bad++; $display("FAIL rmid_async got=%b exp=%b", dut_vec(), 5'b0);
    end
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if ({gnt_rd, rw, busy} !== 3'b111 || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL rmid_regrant got=%b exp=%b", dut_vec(), exp_vec());
    end
    done_rd = 1'b1;
    tick();
    done_rd = 1'b0; req_rd = 1'b0;
    for (int c = 0; c < 6; c++) tick();
  endtask

  task automatic test_random();
    int st[2], len[2], cnt[2];
    bit had[2];
    bit g, r, d;
    apply_reset();
    for (int e = 0; e < 2; e++) begin
      st[e] = 0; len[e] = 0; cnt[e] = 0; had[e] = 1'b0;
    end
    for (int c = 1; c <= 1500; c++) begin
      for (int e = 0; e < 2; e++) begin
        g = (e == 0) ? (m_owner == 1) : (m_owner == 2);
        d = 1'b0;
        if (st[e] == 2) begin
          st[e] = 0;
        end else if (st[e] == 1) begin
          if (g) begin
            had[e] = 1'b1;
            cnt[e]++;
            if (cnt[e] == len[e]) begin
              d = 1'b1; st[e] = 2;
            end else if ($urandom_range(0, 59) == 0) begin
              st[e] = 0;
            end
          end else if (had[e]) begin
            st[e] = 0;
          end
        end else if ($urandom_range(0, 5) == 0) begin
          st[e] = 1; len[e] = $urandom_range(1, T + 6); cnt[e] = 0; had[e] = 1'b0;
        end
        r = (st[e] != 0);
        if (!g && st[e] != 2 && $urandom_range(0, 19) == 0) d = 1'b1;
        if (e == 0) begin
          req_wr = r; done_wr = d;
        end else begin
          req_rd = r; done_rd = d;
        end
      end
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
    end
    req_wr = 1'b0; req_rd = 1'b0; done_wr = 1'b0; done_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_tie();
    test_round_robin();
    test_timeout();
    test_collision();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 Parameter GUARD_CYCLES, default 4: idle clk cycles between bus tenures.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000: maximum grant tenure in clk cycles.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_wr  input  1  write engine requests the I2C bus; level, held until done_wr.
REQ-006 req_rd  input  1  read engine requests the I2C bus; level, held until done_rd.
REQ-007 done_wr  input  1  write engine transaction complete; one-cycle pulse.
REQ-008 done_rd  input  1  read engine transaction complete; one-cycle pulse.
REQ-009 gnt_wr  output  1  write engine owns the bus.
REQ-010 gnt_rd  output  1  read engine owns the bus.
REQ-011 rw  output  1  mux select to the sclk/sdat multiplexor: 1 = read path, 0 = write path.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 timeout_err  output  1  one-cycle pulse when a tenure is forcibly ended.

Function
REQ-014 States SHALL be IDLE, GRANT_WR, GRANT_RD and GUARD; all outputs SHALL be registered.
REQ-015 In IDLE, a single request SHALL move to the matching GRANT state on the next edge, with its gnt high from that edge (1-cycle request-to-grant latency).
REQ-016 In IDLE with req_wr and req_rd both high, the requester not served last SHALL win; the last-served flag SHALL reset to "read", so write wins the first tie.
REQ-017 gnt_wr and gnt_rd SHALL never be high in the same cycle.
REQ-018 In a GRANT state, the owner's done pulse or the owner dropping its req SHALL move to GUARD on the next edge, with gnt low from that edge.
REQ-019 A done or req on the non-owning requester SHALL be ignored during a grant; a pending request SHALL stay pending.
REQ-020 A tenure counter SHALL clear on GRANT entry and increment each GRANT cycle; at TIMEOUT_CYCLES-1 without done the arbiter SHALL move to GUARD, drop gnt and pulse timeout_err for one cycle.
REQ-021 If done arrives in the same cycle the counter reaches TIMEOUT_CYCLES-1, done SHALL take priority and timeout_err SHALL stay low.
REQ-022 GUARD SHALL last exactly GUARD_CYCLES cycles, then go to IDLE; GUARD_CYCLES = 0 SHALL go from GRANT straight to IDLE.
REQ-023 rw SHALL be 1 in GRANT_RD and in the GUARD that follows a read tenure, and 0 in IDLE, GRANT_WR and a post-write GUARD, so the mux does not switch mid-tenure or mid-guard.
REQ-024 rw SHALL be updated on the same edge that gnt_rd rises, so the mux path is selected before the read engine drives.
REQ-025 The last-served flag SHALL update on GRANT entry.
REQ-026 Counter widths SHALL be $clog2(max(TIMEOUT_CYCLES, GUARD_CYCLES)+1); counters SHALL saturate and never wrap.

Reset
REQ-027 On rst_n low, the arbiter SHALL immediately enter IDLE and set gnt_wr=0, gnt_rd=0, rw=0, busy=0, timeout_err=0, counters=0 and last-served=read, regardless of clk.
REQ-028 Reset asserted mid-tenure SHALL drop the grant asynchronously; after deassertion, arbitration SHALL restart from IDLE on the first clk edge.

Structure
REQ-029 Shared package i2c_arb_pkg SHALL hold the state encoding (2-bit) and the default GUARD_CYCLES and TIMEOUT_CYCLES constants.
REQ-030 One sub-module, i2c_arb_timer (loadable saturating counter with terminal-count flag), SHALL be instantiated once and time both GUARD and tenure.

Verification
REQ-031 Single write: req_wr rises at cycle 0 -> gnt_wr=1 at cycle 1, rw=0; done_wr at cycle 10 -> gnt_wr=0 at cycle 11, busy=0 at cycle 15.
REQ-032 Tie: req_wr and req_rd rise together after reset -> write granted first; after done_wr and 4 guard cycles -> gnt_rd=1 with rw=1.
REQ-033 Round-robin: both held high for 4 tenures -> grant order WR, RD, WR, RD, and the two gnt lines never overlap.
REQ-034 Timeout: TIMEOUT_CYCLES=20, gnt_rd with no done -> gnt_rd drops 20 cycles after grant, timeout_err pulses once, then GUARD.
REQ-035 Done/timeout collision: done_rd on the cycle the counter reaches 19 -> timeout_err stays 0.
REQ-036 Reset mid-tenure: rst_n low during GRANT_RD, between clk edges -> gnt_rd=0 and rw=0 without a clk edge; req_rd still high after release -> gnt_rd=1 one cycle after the first edge.
